// File: rtl/serial_parity_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Recomputes XOR parity and reports the word with parity/framing status.
module serial_parity_checker #(
  parameter int DATA_W     = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nx;
  logic [DATA_W-1:0] data_q, data_d;
  logic              acc_q, acc_d;
  logic              pend_q, pend_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  // New bits enter at the MSB so the first data bit lands in bit 0.
  if (DATA_W == 1) begin : g_w1
    assign shift_nx = rx;
  end else begin : g_wn
    assign shift_nx = {rx, shift_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    pend_d  = pend_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
        end
        DATA: begin
          shift_d = shift_nx;
          acc_d   = acc_q ^ rx;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          pend_d  = acc_q ^ rx ^ PARITY_ODD;
          state_d = STOP;
        end
        STOP: begin
          data_d  = shift_q;
          perr_d  = pend_q;
          ferr_d  = ~rx;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= 1'b0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = busy_q;

endmodule
